// File: rtl/pipe_pkg.sv
// Shared types and defaults for the parametrised pipeline stage register.
// The optional performance counters are enabled by defining PIPE_PERF_EN.
package pipe_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W  = 16;

  // Occupancy of the stage, derived from the two valid flags.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // Map the valid flags onto the occupancy encoding; skid is never valid
  // without main, so that combination folds into EMPTY.
  function automatic pipe_state_t state_decode(input logic main_v, input logic skid_v);
    pipe_state_t st;
    if (!main_v) begin
      st = ST_EMPTY;
    end else if (!skid_v) begin
      st = ST_HALF;
    end else begin
      st = ST_FULL;
    end
    return st;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter that adds 0..2 per cycle and sticks at all-ones.
// Only instantiated when PIPE_PERF_EN is defined.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum_s;

  // Add the increment with one guard bit and clamp on overflow.
  always_comb begin
    sum_s = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, inc};
    if (sum_s[CNT_W]) begin
      cnt_d = {CNT_W{1'b1}};
    end else begin
      cnt_d = sum_s[CNT_W-1:0];
    end
  end

  // Counter register, cleared only by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a 2-entry skid
// buffer (main + skid) so in_ready depends only on registered state and
// freeze, plus flush and freeze controls.
// Define PIPE_PERF_EN to add the stall_cnt / kill_cnt performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
`endif
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_fire_s;
  logic              out_fire_s;
  pipe_state_t       state_s;

  // Handshake outputs come straight from registered flags gated by freeze.
  assign in_ready   = ~skid_v_q & ~freeze;
  assign out_valid  = main_v_q & ~freeze;
  assign out_data   = main_data_q;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign state_s    = state_decode(main_v_q, skid_v_q);

  // Next-state selection: flush clears, freeze holds, else move entries FIFO-wise.
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_data_d = BUBBLE_VAL;
      skid_data_d = BUBBLE_VAL;
    end else if (freeze) begin
      main_v_d    = main_v_q;
      skid_v_d    = skid_v_q;
    end else begin
      case (state_s)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_v_d    = 1'b1;
            main_data_d = in_data;
          end else begin
            main_v_d    = 1'b0;
          end
        end
        ST_HALF: begin
          if (in_fire_s && out_fire_s) begin
            main_data_d = in_data;
          end else if (in_fire_s) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
          end else if (out_fire_s) begin
            main_v_d    = 1'b0;
            main_data_d = BUBBLE_VAL;
          end else begin
            main_v_d    = 1'b1;
          end
        end
        ST_FULL: begin
          // The skid entry only moves forward into main, never past it.
          if (out_fire_s) begin
            skid_v_d    = 1'b0;
            main_data_d = skid_data_q;
            skid_data_d = BUBBLE_VAL;
          end else begin
            skid_v_d    = 1'b1;
          end
        end
        default: begin
          main_v_d    = 1'b0;
          skid_v_d    = 1'b0;
          main_data_d = BUBBLE_VAL;
          skid_data_d = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Storage registers; reset loads the bubble into both entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= BUBBLE_VAL;
      skid_data_q <= BUBBLE_VAL;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [1:0] stall_inc_s;
  logic [1:0] kill_inc_s;

  // Stall counts a held entry that cannot leave; kill counts entries a flush drops.
  always_comb begin
    stall_inc_s = {1'b0, main_v_q & (freeze | ~out_ready)};
    if (flush) begin
      kill_inc_s = {1'b0, main_v_q} + {1'b0, skid_v_q};
    end else begin
      kill_inc_s = 2'd0;
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc_s),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
    .clk (clk),
    .rst (rst),
    .inc (kill_inc_s),
    .cnt (kill_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a queue scoreboard holds the
// payloads the stage should contain and predicts handshakes and out_data.
module tb_pipe_stage_reg;

  localparam int          DW  = 64;
  localparam int          CW  = 4;
  localparam logic [63:0] BUB = 64'hBBBB_0000_0000_BBBB;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          freeze = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef PIPE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] kill_cnt;
`endif

  logic [63:0] sb_q[$];
  int  err_cnt = 0;
  int  chk_cnt = 0;
  int  stall_exp = 0;
  int  kill_exp = 0;
  bit  model_ok = 1'b0;
  bit  last_acc = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W     (DW),
    .BUBBLE_VAL (BUB),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Check outputs against the model, advance the model, then clock once.
  task automatic cycle();
    bit exp_ir, exp_ov, fi, fo;
    logic [63:0] exp_data;
    #1;
    if (model_ok) begin
      exp_ir = (sb_q.size() < 2) && !freeze;
      exp_ov = (sb_q.size() > 0) && !freeze;
      if (sb_q.size() > 0) exp_data = sb_q[0];
      else                 exp_data = BUB;
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      check_eq("out_data", out_data, exp_data);
`ifdef PIPE_PERF_EN
      check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      check_eq("kill_cnt", 64'(kill_cnt), 64'(kill_exp));
`endif
    end
    fi = 1'b0;
    fo = 1'b0;
    if (!rst) begin
      sb_q.delete();
      stall_exp = 0;
      kill_exp  = 0;
    end else begin
      if (sb_q.size() > 0 && (freeze || !out_ready))
        stall_exp = (stall_exp < CNT_MAX) ? stall_exp + 1 : CNT_MAX;
      if (flush) begin
        kill_exp = kill_exp + sb_q.size();
        if (kill_exp > CNT_MAX) kill_exp = CNT_MAX;
        sb_q.delete();
      end else if (!freeze) begin
        fo = (sb_q.size() > 0) && out_ready;
        fi = in_valid && (sb_q.size() < 2);
        if (fo) void'(sb_q.pop_front());
        if (fi) sb_q.push_back(in_data);
      end
    end
    last_acc = fi;
    @(posedge clk);
    #1;
    model_ok = 1'b1;
  endtask

  // Offer one payload until the stage takes it (bounded wait).
  task automatic push(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    check_eq("push_accept", {63'd0, last_acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();

    // 1. Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(64'(i));
    repeat (3) cycle();

    // 2. Backpressure into the skid entry, then drain in order
    out_ready = 1'b0;
    push(64'hA);
    push(64'hB);
    in_valid = 1'b1;
    in_data  = 64'hC;
    cycle();
    check_eq("full_holds_c", {63'd0, last_acc}, 64'd0);
    cycle();
    check_eq("full_holds_c2", {63'd0, last_acc}, 64'd0);
    out_ready = 1'b1;
    push(64'hC);
    repeat (4) cycle();

    // 3. Flush while FULL with an incoming payload
    out_ready = 1'b0;
    push(64'h11);
    push(64'h12);
    in_valid  = 1'b1;
    in_data   = 64'h99;
    out_ready = 1'b1;
    flush     = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) cycle();

    // 4. Freeze while HALF
    out_ready = 1'b0;
    push(64'h44);
    freeze    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    out_ready = 1'b1;
    repeat (3) cycle();
    freeze   = 1'b0;
    in_valid = 1'b0;
    repeat (3) cycle();

    // 5. Reset beats flush while FULL
    out_ready = 1'b0;
    push(64'h71);
    push(64'h72);
    rst   = 1'b0;
    flush = 1'b1;
    cycle();
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    push(64'h73);
    repeat (2) cycle();

    // 6. Stall counter saturation
    out_ready = 1'b0;
    push(64'h66);
    repeat (20) cycle();
    out_ready = 1'b1;
    repeat (2) cycle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    in_valid  = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
